// File: rtl/bus_dma_engine_pkg.sv
// bus_dma_engine_pkg: shared state encoding and constants for the bus DMA engine
package bus_dma_engine_pkg;
  typedef enum logic [2:0] {IDLE, REQ, RD_ADDR, RD_CAP, TURN, WR, DONE} state_e;
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;
  localparam logic [7:0] PARK_ADDR_DEF = 8'hFF;
endpackage

// File: rtl/bus_dma_tristate.sv
// bus_dma_tristate: registered data byte with gated drive onto the shared data bus
module bus_dma_tristate (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [7:0] load_data_i,
  input  logic       oe_i,
  inout  wire  [7:0] bus_data_io
);
  logic [7:0] data_q, data_d;
  assign data_d = load_i ? load_data_i : data_q;
  always_ff @(posedge clk_i) data_q <= reset_i ? '0 : data_d;
  assign bus_data_io = oe_i ? data_q : 'z;
endmodule

// File: rtl/bus_dma_engine.sv
// bus_dma_engine: second bus initiator that copies or fills byte blocks over the shared bus
module bus_dma_engine
  import bus_dma_engine_pkg::*;
#(
  parameter logic [7:0] PARK_ADDR = PARK_ADDR_DEF,
  parameter int         LEN_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [7:0]           src_i,
  input  logic [7:0]           dst_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic [7:0]           fill_data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 bus_req_o,
  input  logic                 bus_gnt_i,
  output logic [7:0]           bus_addr_out_o,
  output logic                 bus_we_out_o,
  inout  wire  [7:0]           bus_data_io
);
  state_e state_q, state_d, resume;
  logic [7:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic mode_q, mode_d, busy_q, busy_d, done_q, done_d;
  logic accept, wr_go, cap_go;
  assign accept = start_i && state_q == IDLE;
  assign wr_go  = bus_gnt_i && state_q == WR;
  assign cap_go = bus_gnt_i && state_q == RD_CAP;
  assign resume = mode_q == MODE_COPY ? RD_ADDR : TURN;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = !start_i ? IDLE : len_i == '0 ? DONE : REQ;
      REQ:     state_d = !bus_gnt_i ? REQ : mode_q == MODE_COPY ? RD_ADDR : WR;
      RD_ADDR: state_d = bus_gnt_i ? RD_CAP : resume;
      RD_CAP:  state_d = bus_gnt_i ? TURN : resume;
      TURN:    state_d = bus_gnt_i ? WR : resume;
      WR:      state_d = wr_go && rem_q == LEN_WIDTH'(1) ? DONE : resume;
      default: state_d = IDLE;
    endcase
  end
  assign mode_d = accept ? mode_i : mode_q;
  assign src_d  = accept ? src_i : wr_go ? src_q + 8'd1 : src_q;
  assign dst_d  = accept ? dst_i : wr_go ? dst_q + 8'd1 : dst_q;
  assign rem_d  = accept ? len_i : wr_go ? rem_q - LEN_WIDTH'(1) : rem_q;
  assign busy_d = state_d inside {REQ, RD_ADDR, RD_CAP, TURN, WR};
  assign done_d = state_d == DONE;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      mode_q  <= MODE_COPY;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy_o         = busy_q;
  assign bus_req_o      = busy_q;
  assign done_o         = done_q;
  assign bus_we_out_o   = wr_go;
  assign bus_addr_out_o = !bus_gnt_i || !busy_q || state_q inside {REQ, TURN} ? PARK_ADDR :
                          state_q == WR ? dst_q : src_q;
  bus_dma_tristate u_tri (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      ((accept && mode_i == MODE_FILL) || cap_go),
    .load_data_i (cap_go ? bus_data_io : fill_data_i),
    .oe_i        (wr_go),
    .bus_data_io (bus_data_io)
  );
endmodule

// File: tb/tb_bus_dma_engine.sv
// tb_bus_dma_engine: scoreboard bench with a bus-mapped RAM responder for bus_dma_engine
module tb_bus_dma_engine;
  typedef struct packed {logic [7:0] a; logic [7:0] d; logic k;} wr_t;
  logic clk = 1'b0, rst, start, mode, gnt;
  logic [7:0] src, dst, len, fill;
  logic busy, done, req, dma_we;
  logic [7:0] dma_addr, bus_addr, ram_rd_q;
  logic bus_we, ram_oe_q;
  wire [7:0] bus;
  logic [7:0] mem [128];
  logic [7:0] ref_mem [128];
  bit ref_unk [128];
  wr_t exp_q [$];
  int n_vec = 0, n_err = 0, contend = 0;
  always #5 clk = ~clk;
  bus_dma_engine dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .start_i        (start),
    .mode_i         (mode),
    .src_i          (src),
    .dst_i          (dst),
    .len_i          (len),
    .fill_data_i    (fill),
    .busy_o         (busy),
    .done_o         (done),
    .bus_req_o      (req),
    .bus_gnt_i      (gnt),
    .bus_addr_out_o (dma_addr),
    .bus_we_out_o   (dma_we),
    .bus_data_io    (bus)
  );
  function automatic logic [7:0] init_val(input int i);
    case (i)
      16: return 8'hA1;
      17: return 8'hB2;
      18: return 8'hC3;
      19: return 8'hD4;
      default: return 8'(i * 7 + 3);
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  assign bus_addr = gnt ? dma_addr : 8'hFF;
  assign bus_we   = gnt & dma_we;
  assign bus      = ram_oe_q ? ram_rd_q : 8'hzz;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
      ram_oe_q <= 1'b0;
      ram_rd_q <= 8'h00;
    end else begin
      if (bus_we && bus_addr < 8'h80) mem[bus_addr[6:0]] <= bus;
      ram_oe_q <= !bus_we && bus_addr < 8'h80;
      ram_rd_q <= mem[bus_addr[6:0]];
    end
  end
  always @(negedge clk) begin
    wr_t e;
    if (ram_oe_q && dma_we) contend++;
    if (gnt && dma_we) begin
      if (exp_q.size() == 0) chk("spurious_wr", {dma_addr, bus}, 0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", dma_addr, e.a);
        if (e.k) chk("wr_data", bus, e.d);
      end
    end
    if (!gnt && busy) begin
      chk("park_addr", dma_addr, 8'hFF);
      chk("park_we", dma_we, 0);
      chk("park_req", req, 1);
    end
  end
  task automatic ram_cmp(input string tag);
    int diffs = 0;
    for (int i = 0; i < 128; i++) if (!ref_unk[i] && mem[i] !== ref_mem[i]) diffs++;
    chk(tag, diffs, 0);
  endtask
  task automatic run(input logic m, input logic [7:0] s0, input logic [7:0] d0, input logic [7:0] n,
                     input logic [7:0] f, input int exp_lat, input int drop_at, input int rst_at);
    int lat = 0;
    logic saw_req = 1'b0;
    logic [7:0] s, d;
    wr_t e;
    for (int i = 0; i < int'(n); i++) begin
      s = s0 + 8'(i);
      d = d0 + 8'(i);
      e.a = d;
      e.k = m || (s < 8'h80 && !ref_unk[s[6:0]]);
      e.d = m ? f : e.k ? ref_mem[s[6:0]] : 8'h00;
      if (d < 8'h80) begin
        ref_mem[d[6:0]] = e.d;
        ref_unk[d[6:0]] = !e.k;
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b1; mode = m; src = s0; dst = d0; len = n; fill = f;
    @(negedge clk);
    chk("done_at_start", done, 0);
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      gnt = !(drop_at > 0 && k >= drop_at && k < drop_at + 5);
      if (rst_at > 0) rst = k == rst_at;
      @(negedge clk);
      saw_req |= req;
      if (rst_at > 0 && k == rst_at + 1) begin
        chk("rst_busy", busy, 0);
        chk("rst_req", req, 0);
        chk("rst_done", done, 0);
        chk("rst_we", dma_we, 0);
        chk("rst_addr", dma_addr, 8'hFF);
        lat = k;
        break;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    if (rst_at > 0) begin
      chk("rst_no_early_done", lat, rst_at + 1);
      chk("rst_sb_left", exp_q.size(), 2);
    end else begin
      chk("latency", lat, exp_lat);
      chk("busy_at_done", busy, 0);
      chk("req_at_done", req, 0);
      chk("sb_left", exp_q.size(), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("done_once", done, 0);
    end
    if (n == 0) chk("len0_req", saw_req, 0);
    exp_q.delete();
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; gnt = 1'b1;
    src = '0; dst = '0; len = '0; fill = '0;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = init_val(i);
      ref_unk[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_req", req, 0);
    chk("reset_we", dma_we, 0);
    chk("reset_addr", dma_addr, 8'hFF);
    @(posedge clk);
    #1 rst = 1'b0;
    run(1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 18, 0, 0);
    chk("copy4_b0", mem['h40], 8'hA1);
    chk("copy4_b3", mem['h43], 8'hD4);
    ram_cmp("ram_copy4");
    run(1'b1, 8'h00, 8'h7E, 8'd4, 8'h5A, 9, 0, 0);
    chk("fill_7e", mem['h7E], 8'h5A);
    chk("fill_7f", mem['h7F], 8'h5A);
    ram_cmp("ram_fill");
    run(1'b0, 8'h20, 8'h30, 8'd0, 8'h00, 1, 0, 0);
    ram_cmp("ram_len0");
    run(1'b0, 8'h10, 8'h60, 8'd3, 8'h00, 20, 7, 0);
    chk("gnt_drop_b1", mem['h61], 8'hB2);
    ram_cmp("ram_gnt_drop");
    run(1'b0, 8'hFF, 8'h00, 8'd2, 8'h00, 10, 0, 0);
    chk("wrap_copy", mem[1], mem[0]);
    ram_cmp("ram_wrap");
    run(1'b0, 8'h10, 8'h50, 8'd4, 8'h00, 0, 0, 9);
    chk("bus_contention", contend, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
